// File: rtl/mult_arbiter_pkg.sv
// Shared types and constants for the multiplier arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mult_arbiter_pkg;

    localparam int MULT_W  = 8;
    localparam int PROD_W  = 16;
    localparam int CNT_MAX = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_e;

    // 3:2 carry-save compressor on PROD_W-bit rows.
    // Returns {sum, carry}. The carry is already shifted into its column.
    // Bits carried out of the top are dropped. Every product fits in
    // PROD_W bits, so working modulo 2**PROD_W gives the exact result.
    function automatic logic [2*PROD_W-1:0] csa(
        input logic [PROD_W-1:0] x,
        input logic [PROD_W-1:0] y,
        input logic [PROD_W-1:0] z
    );
        logic [PROD_W-1:0] s;
        logic [PROD_W-1:0] c;
        s = x ^ y ^ z;
        c = ((x & y) | (x & z) | (y & z)) << 1;
        return {s, c};
    endfunction

endpackage

// File: rtl/mult_arbiter_mult.sv
// Unsigned 8x8 multiplier with two independent product paths for cross-checking.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports:
//   a, b            - unsigned operands
//   dadda_product   - reference product; the synthesis tool chooses the reduction tree
//   wallace_product - explicit Wallace carry-save tree over the partial products
module mult_dadda_wallace
    import mult_arbiter_pkg::*;
(
    input  logic [MULT_W-1:0] a,
    input  logic [MULT_W-1:0] b,
    output logic [PROD_W-1:0] dadda_product,
    output logic [PROD_W-1:0] wallace_product
);

    logic [PROD_W-1:0]   pp [MULT_W];
    logic [2*PROD_W-1:0] l1_0, l1_1, l2_0, l2_1, l3_0, l4_0;

    assign dadda_product = PROD_W'(a) * PROD_W'(b);

    // One partial-product row per bit of b, aligned to its weight.
    always_comb begin
        for (int i = 0; i < MULT_W; i++) begin
            pp[i] = b[i] ? (PROD_W'(a) << i) : '0;
        end
    end

    // Row counts per stage: 8 -> 6 -> 4 -> 3 -> 2, then one carry-propagate add.
    assign l1_0 = csa(pp[0], pp[1], pp[2]);
    assign l1_1 = csa(pp[3], pp[4], pp[5]);
    assign l2_0 = csa(l1_0[2*PROD_W-1:PROD_W], l1_0[PROD_W-1:0], l1_1[2*PROD_W-1:PROD_W]);
    assign l2_1 = csa(l1_1[PROD_W-1:0], pp[6], pp[7]);
    assign l3_0 = csa(l2_0[2*PROD_W-1:PROD_W], l2_0[PROD_W-1:0], l2_1[2*PROD_W-1:PROD_W]);
    assign l4_0 = csa(l3_0[2*PROD_W-1:PROD_W], l3_0[PROD_W-1:0], l2_1[PROD_W-1:0]);

    assign wallace_product = l4_0[2*PROD_W-1:PROD_W] + l4_0[PROD_W-1:0];

endmodule

// File: rtl/mult_arbiter_rr_grant.sv
// Round-robin one-hot grant: first set bit of req at or after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; gnt is zero when req is zero.
//
// Ports:
//   req  - request vector, one bit per requester
//   ptr  - index where the search begins (must be < NREQ)
//   gnt  - one-hot grant, never set on a bit whose req is clear
module rr_grant #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt
);

    localparam int SW = IDW + 1;

    logic [SW-1:0]  sum;
    logic [IDW-1:0] idx;

    // Walk offsets from the farthest to the nearest. A later hit overwrites
    // an earlier one, so the requester closest to ptr wins.
    always_comb begin
        gnt = '0;
        sum = '0;
        idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + SW'(k);
            if (sum >= SW'(NREQ)) begin
                sum = sum - SW'(NREQ);
            end
            idx = sum[IDW-1:0];
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter that shares one 8x8 multiplier among NREQ requesters.
// Latency: the response is registered one edge after the request handshake edge.
//          It is two edges after the request is presented to an idle arbiter.
// Backpressure: rsp_* hold while rsp_valid & !rsp_ready, and no grants are issued meanwhile.
//
// Ports:
//   clk, rst_n            - clock; synchronous active-low reset
//   req_valid/req_ready   - per-requester handshake; req_ready is one-hot
//   req_a, req_b          - packed operands, requester i in bits [8i+7:8i]
//   rsp_valid/rsp_ready   - response handshake
//   rsp_id                - requester index served
//   rsp_product           - 16-bit unsigned product
//   rsp_mismatch          - the two multiplier paths disagreed on this response
//   mismatch_cnt          - saturating count of mismatching responses
module mult_arbiter
    import mult_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [MULT_W*NREQ-1:0] req_a,
    input  logic [MULT_W*NREQ-1:0] req_b,
    output logic [NREQ-1:0]        req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [PROD_W-1:0]      rsp_product,
    output logic                   rsp_mismatch,
    output logic [7:0]             mismatch_cnt
);

    state_e            state_q,        state_d;
    logic [IDW-1:0]    ptr_q,          ptr_d;
    logic [MULT_W-1:0] op_a_q,         op_a_d;
    logic [MULT_W-1:0] op_b_q,         op_b_d;
    logic              rsp_valid_q,    rsp_valid_d;
    logic [IDW-1:0]    rsp_id_q,       rsp_id_d;
    logic [PROD_W-1:0] rsp_product_q,  rsp_product_d;
    logic              rsp_mismatch_q, rsp_mismatch_d;
    logic [7:0]        mismatch_cnt_q, mismatch_cnt_d;

    logic [NREQ-1:0]   gnt;
    logic [IDW-1:0]    gnt_id;
    logic [IDW-1:0]    ptr_nxt;
    logic [MULT_W-1:0] sel_a;
    logic [MULT_W-1:0] sel_b;
    logic              grant_en;
    logic              hs;
    logic [PROD_W-1:0] dadda_product;
    logic [PROD_W-1:0] wallace_product;
    logic              mult_mismatch;

    rr_grant #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_grant (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (gnt)
    );

    mult_dadda_wallace u_mult (
        .a               (op_a_q),
        .b               (op_b_q),
        .dadda_product   (dadda_product),
        .wallace_product (wallace_product)
    );

    assign mult_mismatch = (dadda_product != wallace_product);

    // A grant is possible when idle or when the pending response retires
    // this cycle. Holding rst_n low forces req_ready low without waiting for an edge.
    assign grant_en  = rst_n &&
                       ((state_q == IDLE) || ((state_q == RESP) && rsp_ready));
    assign req_ready = grant_en ? gnt : '0;
    // gnt only ever selects a valid requester, so any valid bit means a handshake.
    assign hs        = grant_en && (|req_valid);

    // Decode the one-hot grant into an index and the matching operands.
    always_comb begin
        gnt_id = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                gnt_id = IDW'(i);
                sel_a  = req_a[MULT_W*i +: MULT_W];
                sel_b  = req_b[MULT_W*i +: MULT_W];
            end
        end
    end

    assign ptr_nxt = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        op_a_d         = op_a_q;
        op_b_d         = op_b_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_id_d       = rsp_id_q;
        rsp_product_d  = rsp_product_q;
        rsp_mismatch_d = rsp_mismatch_q;
        mismatch_cnt_d = mismatch_cnt_q;

        case (state_q)
            IDLE: begin
                if (hs) begin
                    op_a_d   = sel_a;
                    op_b_d   = sel_b;
                    rsp_id_d = gnt_id;
                    ptr_d    = ptr_nxt;
                    state_d  = CALC;
                end
            end

            CALC: begin
                rsp_product_d  = dadda_product;
                rsp_mismatch_d = mult_mismatch;
                rsp_valid_d    = 1'b1;
                if (mult_mismatch && (mismatch_cnt_q != 8'(CNT_MAX))) begin
                    mismatch_cnt_d = mismatch_cnt_q + 8'd1;
                end
                state_d = RESP;
            end

            RESP: begin
                if (rsp_ready) begin
                    // Retire, then start the next request in the same cycle if one
                    // handshakes. rsp_id can update here because rsp_valid drops together with it.
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                    if (hs) begin
                        op_a_d   = sel_a;
                        op_b_d   = sel_b;
                        rsp_id_d = gnt_id;
                        ptr_d    = ptr_nxt;
                        state_d  = CALC;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            ptr_q          <= '0;
            op_a_q         <= '0;
            op_b_q         <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_id_q       <= '0;
            rsp_product_q  <= '0;
            rsp_mismatch_q <= 1'b0;
            mismatch_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            op_a_q         <= op_a_d;
            op_b_q         <= op_b_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_id_q       <= rsp_id_d;
            rsp_product_q  <= rsp_product_d;
            rsp_mismatch_q <= rsp_mismatch_d;
            mismatch_cnt_q <= mismatch_cnt_d;
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_id       = rsp_id_q;
    assign rsp_product  = rsp_product_q;
    assign rsp_mismatch = rsp_mismatch_q;
    assign mismatch_cnt = mismatch_cnt_q;

endmodule
